regfile_write_buffer: RTL
=========================

# regfile_write_buffer

Write-side companion to the `RegisterFile` block. It accepts register writeback requests from the execute and load paths through a valid/ready handshake and buffers them in a small FIFO. It drains one entry per clock into the register file's single write port (`WEn`/`Write_Adr`/`Write_Data`). It also snoops the two read addresses and forwards the youngest pending value for each, so a reader never sees stale data while a write is still queued.

## Interface
- `DEPTH`, 4, number of FIFO entries; must be a power of two, 2 or more.
- `DATA_WIDTH`, 32, register data width.
- `ADDR_WIDTH`, 5, register address width.

Ports:
- `Clock`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state immediately.
- `In_Valid`  in  1  writeback request present.
- `In_Ready`  out  1  buffer can accept a request.
- `In_Adr`  in  ADDR_WIDTH  destination register.
- `In_Data`  in  DATA_WIDTH  value to write.
- `Hold`  in  1  suspends draining; forces `WEn`=0.
- `WEn`  out  1  write enable to the register file.
- `Write_Adr`  out  ADDR_WIDTH  register file write address.
- `Write_Data`  out  DATA_WIDTH  register file write data.
- `Read_Adr_1`, `Read_Adr_2`  in  ADDR_WIDTH  snooped register file read addresses.
- `Fwd_Hit_1`, `Fwd_Hit_2`  out  1  a pending entry matches the corresponding read address.
- `Fwd_Data_1`, `Fwd_Data_2`  out  DATA_WIDTH  youngest matching pending value; 0 when there is no hit.
- `Count`  out  log2(DEPTH)+1  number of occupied entries.

## Operation
- The FIFO uses head/tail pointers that wrap modulo DEPTH, plus an occupancy counter. Full is `Count`==DEPTH; empty is `Count`==0.
- `In_Ready` = !full. It is combinational from `Count` and does not depend on a same-cycle pop.
- Push at an edge when `In_Valid` && `In_Ready` && `In_Adr`!=0: store {`In_Adr`, `In_Data`} at tail, then tail+1.
- A request with `In_Adr`==0 is accepted (the handshake completes) but discarded: nothing is stored and `Count` is unchanged.
- `In_Valid` while full: not accepted. The producer must hold the request until `In_Ready`=1.
- Drain: `WEn` = !empty && !`Hold`. `Write_Adr`/`Write_Data` present the head entry when not empty, and 0 when empty.
- Pop at every edge where `WEn`=1: head+1.
- Simultaneous push and pop: `Count` is unchanged and both pointers advance. This is legal when full only if the push is not attempted, since `In_Ready`=0.
- Forwarding for each read port:
  - Compare the read address against every occupied entry, head through tail-1.
  - Hit when the read address is nonzero and matches. The data comes from the youngest match, i.e. the one nearest the tail.
  - Read address 0 never hits.
  - The head entry being written this cycle still counts as pending.
  - The same-cycle incoming request is not forwarded.
- Reset (asynchronous, at any time, including mid-drain):
  - Pointers and `Count` go to 0.
  - `WEn`=0, `Write_Adr`=0, `Write_Data`=0, `In_Ready`=1, `Fwd_Hit_*`=0, `Fwd_Data_*`=0.
  - Pending entries are lost.
  - While `Reset`=1, no push or pop occurs.

## Timing
- Push-to-write latency: a request accepted at edge N into an empty, un-held buffer drives `WEn`=1 between edges N and N+1. The register file captures it at edge N+1.
- Forwarding hit is visible combinationally after the push edge N. It remains until the edge that pops that entry, or until the entry is superseded by a younger match.
- Throughput: one push and one pop per cycle sustained. The buffer never fills unless `Hold` is asserted.
- `Hold` takes effect combinationally on `WEn` in the same cycle. Deasserting `Hold` resumes draining at the next edge.
- Pointer wrap: after DEPTH pushes, tail returns to 0 with no gap or duplicate.

## Test plan
- Reset, then push (adr=1, data=32) with `Hold`=0. Required:
  - `WEn`=1, `Write_Adr`=1, `Write_Data`=32 for exactly one cycle.
  - `Count` goes 1 then 0.
  - `Fwd_Hit_1`=1 with `Read_Adr_1`=1 during that cycle.
- Push adr=0 data=64. Required: `In_Ready`=1, `Count` stays 0, `WEn` stays 0.
- `Hold`=1; push adr 1..4 with data 10,20,30,40. Required:
  - `Count`=4 and `In_Ready`=0.
  - A fifth push (adr=5) is not accepted.
  - After `Hold`=0, writes appear in order 10,20,30,40 on consecutive cycles.
- `Hold`=1; push (3,128) then (3,256); `Read_Adr_1`=`Read_Adr_2`=3. Required:
  - `Fwd_Data_1`=`Fwd_Data_2`=256.
  - After draining both entries, `Fwd_Hit_*`=0.
- Continuous push every cycle for 10 cycles with `Hold`=0. Required:
  - `Count` never exceeds 1.
  - Wrap-around is correct and every value is written once, in order.
- Fill 3 entries, assert `Reset` mid-cycle between edges. Required:
  - `WEn`=0 and `Count`=0 immediately, without waiting for an edge.
  - After `Reset`=0, no stale write appears.

Source files
------------

// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer
// Small FIFO that queues register writebacks and drains one entry per clock
// into the single register-file write port. Pending entries are snooped by
// both read ports so a reader sees the youngest queued value for its register.
module regfile_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic [ADDR_WIDTH-1:0]   In_Adr,
  input  logic [DATA_WIDTH-1:0]   In_Data,
  input  logic                    Hold,
  output logic                    WEn,
  output logic [ADDR_WIDTH-1:0]   Write_Adr,
  output logic [DATA_WIDTH-1:0]   Write_Data,
  input  logic [ADDR_WIDTH-1:0]   Read_Adr_1,
  input  logic [ADDR_WIDTH-1:0]   Read_Adr_2,
  output logic                    Fwd_Hit_1,
  output logic                    Fwd_Hit_2,
  output logic [DATA_WIDTH-1:0]   Fwd_Data_1,
  output logic [DATA_WIDTH-1:0]   Fwd_Data_2,
  output logic [$clog2(DEPTH):0]  Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO state
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [ADDR_WIDTH-1:0] r_adr  [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];

  // Handshake / drain decode
  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  // Per-slot occupancy and address-match vectors
  logic [PTR_W-1:0] w_age [DEPTH];
  logic [DEPTH-1:0] w_occ;
  logic [DEPTH-1:0] w_match_1;
  logic [DEPTH-1:0] w_match_2;
  logic [PTR_W-1:0] w_idx;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign In_Ready = !w_full;
  assign Count    = r_count;

  // Address-0 requests complete the handshake but are never stored.
  // Reset is folded in so the unreset storage array cannot be written
  // while the pointers are held in reset.
  assign w_push = In_Valid && !w_full && (In_Adr != '0) && !Reset;

  assign WEn        = !w_empty && !Hold;
  assign w_pop      = WEn;
  assign Write_Adr  = w_empty ? '0 : r_adr[r_head];
  assign Write_Data = w_empty ? '0 : r_data[r_head];

  // A slot is pending when its distance from head is below the occupancy.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign w_age[gi]     = PTR_W'(gi) - r_head;
      assign w_occ[gi]     = (CNT_W'(w_age[gi]) < r_count);
      assign w_match_1[gi] = w_occ[gi] && (Read_Adr_1 != '0) && (r_adr[gi] == Read_Adr_1);
      assign w_match_2[gi] = w_occ[gi] && (Read_Adr_2 != '0) && (r_adr[gi] == Read_Adr_2);
    end
  endgenerate

  // Walk slots oldest to youngest so the last match (nearest tail) wins
  always_comb begin
    Fwd_Hit_1  = 1'b0;
    Fwd_Hit_2  = 1'b0;
    Fwd_Data_1 = '0;
    Fwd_Data_2 = '0;
    w_idx      = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PTR_W'(k);
      if (w_match_1[w_idx]) begin
        Fwd_Hit_1  = 1'b1;
        Fwd_Data_1 = r_data[w_idx];
      end
      if (w_match_2[w_idx]) begin
        Fwd_Hit_2  = 1'b1;
        Fwd_Data_2 = r_data[w_idx];
      end
    end
  end

  // Pointer and occupancy update; reset drops all pending entries
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_adr[r_tail]  <= In_Adr;
      r_data[r_tail] <= In_Data;
    end
  end

endmodule
